// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
// Shared constants and helpers for the multiplexed 7-segment display path.
//   SEG_BLANK    : active-low segment pattern with every segment off
//   AN_NONE      : active-low anode vector with every digit off (MAX_DIGITS wide)
//   an_onehot_n  : active-low one-hot anode vector for a digit index
// Anode vectors are built MAX_DIGITS wide; users truncate to their digit count.
// ---------------------------------------------------------------------------
package seg_disp_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [6:0]            SEG_BLANK = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_NONE   = '1;

  // Digit idx enabled (driven low), all other anodes high.
  function automatic logic [MAX_DIGITS-1:0] an_onehot_n(input int unsigned idx);
    logic [MAX_DIGITS-1:0] onehot;
    onehot = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
    onehot = onehot << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_decoder
// Combinational hex-to-7-segment decoder, active-low outputs.
// Ports:
//   i_hex   in  4  hex nibble 0-F
//   o_seg_n out 7  active-low segments, [0]=a ... [6]=g
// ---------------------------------------------------------------------------
module seven_seg_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_n
);

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_hex)
      4'h0: o_seg_n = 7'b1000000;
      4'h1: o_seg_n = 7'b1111001;
      4'h2: o_seg_n = 7'b0100100;
      4'h3: o_seg_n = 7'b0110000;
      4'h4: o_seg_n = 7'b0011001;
      4'h5: o_seg_n = 7'b0010010;
      4'h6: o_seg_n = 7'b0000010;
      4'h7: o_seg_n = 7'b1111000;
      4'h8: o_seg_n = 7'b0000000;
      4'h9: o_seg_n = 7'b0010000;
      4'hA: o_seg_n = 7'b0001000;
      4'hB: o_seg_n = 7'b0000011;
      4'hC: o_seg_n = 7'b1000110;
      4'hD: o_seg_n = 7'b0100001;
      4'hE: o_seg_n = 7'b0000110;
      4'hF: o_seg_n = 7'b0001110;
      default: o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes one hex decoder across NUM_DIGITS common-anode digits.
// Loaded digits land in a holding register and are copied to a shadow
// register only at frame boundaries, so a scan frame is never torn. Each
// digit slot starts with BLANK_CYCLES of all-anodes-off dead time.
// Parameters:
//   NUM_DIGITS   digits per frame (>=1)
//   SCAN_DIV     clock cycles per digit slot (>= BLANK_CYCLES+2)
//   BLANK_CYCLES dead-time cycles at the start of each slot (>=1)
// Ports:
//   i_clk          in  1             rising-edge clock
//   i_rst          in  1             asynchronous active-high reset
//   i_load         in  1             capture i_digits_in / i_blank_in
//   i_digits_in    in  4*NUM_DIGITS  digit k at [4k+3:4k], digit 0 rightmost
//   i_blank_in     in  NUM_DIGITS    1 = digit k dark
//   o_seg_out      out 7             active-low segments, [0]=a ... [6]=g
//   o_an_out       out NUM_DIGITS    active-low anodes, at most one low
//   o_frame_done   out 1             one-cycle pulse per frame boundary
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_blank_in,
  output logic [6:0]              o_seg_out,
  output logic [NUM_DIGITS-1:0]   o_an_out,
  output logic                    o_frame_done
);

  localparam int PRE_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]          r_pre_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_hold;
  logic [NUM_DIGITS-1:0]     r_hold_blank;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [NUM_DIGITS-1:0]     r_shadow_blank;
  logic [6:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_an;
  logic                      r_frame_done;

  logic                      w_pre_tc;
  logic                      w_frame_edge;
  logic [3:0]                w_digit;
  logic [6:0]                w_seg_dec;
  logic [NUM_DIGITS-1:0]     w_an_sel;
  logic                      w_dark;

  assign w_pre_tc     = (r_pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign w_frame_edge = w_pre_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));

  assign w_digit  = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_an_sel = NUM_DIGITS'(an_onehot_n(32'(r_idx)));
  assign w_dark   = (r_pre_cnt < PRE_W'(BLANK_CYCLES)) || r_shadow_blank[r_idx];

  seven_seg_decoder u_dec (
    .i_hex   (w_digit),
    .o_seg_n (w_seg_dec)
  );

  // Slot prescaler and digit index. The index wraps after the last digit;
  // with a single digit it simply stays at 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre_cnt <= '0;
      r_idx     <= '0;
    end else if (w_pre_tc) begin
      r_pre_cnt <= '0;
      if (r_idx == IDX_W'(NUM_DIGITS - 1)) r_idx <= '0;
      else                                 r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // Double buffer. A load on the frame-boundary edge still lets the shadow
  // take the pre-edge hold contents, so new data shows one frame later.
  // Blank bits reset to 1 so nothing lights before the first load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold         <= '0;
      r_hold_blank   <= '1;
      r_shadow       <= '0;
      r_shadow_blank <= '1;
    end else begin
      if (i_load) begin
        r_hold       <= i_digits_in;
        r_hold_blank <= i_blank_in;
      end
      if (w_frame_edge) begin
        r_shadow       <= r_hold;
        r_shadow_blank <= r_hold_blank;
      end
    end
  end

  // Registered display outputs, one cycle behind the counters. Dead time
  // and suppressed digits both force every anode and segment off.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seg        <= SEG_BLANK;
      r_an         <= NUM_DIGITS'(AN_NONE);
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_edge;
      if (w_dark) begin
        r_seg <= SEG_BLANK;
        r_an  <= NUM_DIGITS'(AN_NONE);
      end else begin
        r_seg <= w_seg_dec;
        r_an  <= w_an_sel;
      end
    end
  end

  assign o_seg_out    = r_seg;
  assign o_an_out     = r_an;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2. Expected {frame_done, an_out, seg_out} values for each
// frame are queued and then popped one per cycle against the display.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME_LEN    = NUM_DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digitsIn;
  logic [3:0]  blankIn;
  logic [6:0]  segOut;
  logic [3:0]  anOut;
  logic        frameDone;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } expT;

  expT sb[$];

  logic [6:0] hexTable [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [11:0] DARK = {1'b0, 4'hF, 7'h7F};

  seg_scan_ctrl #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load       (load),
    .i_digits_in  (digitsIn),
    .i_blank_in   (blankIn),
    .o_seg_out    (segOut),
    .o_an_out     (anOut),
    .o_frame_done (frameDone)
  );

  always #5 clk = ~clk;

  // Expected display j cycles after a frame boundary (j = 1..FRAME_LEN).
  function automatic logic [11:0] expectAt(input logic [15:0] d, input logic [3:0] b, input int j);
    int         k;
    int         p;
    logic       fd;
    logic [3:0] oh;
    k  = (j - 1) / SCAN_DIV;
    p  = (j - 1) % SCAN_DIV;
    fd = (j == FRAME_LEN);
    oh = 4'b0001;
    oh = oh << k;
    if (p < BLANK_CYCLES || b[k]) return {fd, 4'hF, 7'h7F};
    return {fd, ~oh, hexTable[d[4*k +: 4]]};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] expVal);
    logic [11:0] obs;
    obs = {frameDone, anOut, segOut};
    assertCount++;
    assert (obs === expVal) else begin
      failCount++;
      $error("[TB] FAIL %s observed fd/an/seg=%h expected=%h", tag, obs, expVal);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [15:0] d, input logic [3:0] b);
    load     = l;
    digitsIn = d;
    blankIn  = b;
  endtask

  // Checks one full frame and optionally drives up to two loads at given
  // cycle positions (0 = none). A load driven at position j is captured on
  // the following rising edge.
  task automatic runFrame(input string tag, input logic [15:0] expD, input logic [3:0] expB,
                          input int loadAt, input logic [15:0] ldD, input logic [3:0] ldB,
                          input int loadAt2, input logic [15:0] ldD2, input logic [3:0] ldB2);
    expT e;
    for (int j = 1; j <= FRAME_LEN; j++)
      sb.push_back('{$sformatf("%s j%0d", tag, j), expectAt(expD, expB, j)});
    for (int j = 1; j <= FRAME_LEN; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checkOutput(e.tag, e.val);
      if (j == loadAt)       applyStimulus(1'b1, ldD, ldB);
      else if (j == loadAt2) applyStimulus(1'b1, ldD2, ldB2);
      else                   load = 1'b0;
    end
  endtask

  // After reset release the display must stay dark until the first
  // frame_done, which is due exactly one frame later.
  task automatic waitFirstFrame(input string tag);
    int cnt;
    bit found;
    cnt   = 0;
    found = 1'b0;
    while (cnt < FRAME_LEN + 8 && !found) begin
      @(negedge clk);
      cnt++;
      if (frameDone) found = 1'b1;
      else checkOutput({tag, " dark"}, DARK);
    end
    assertCount++;
    assert (found && cnt == FRAME_LEN) else begin
      failCount++;
      $error("[TB] FAIL %s first frame_done after %0d cycles (found=%0d), expected %0d", tag, cnt, found, FRAME_LEN);
    end
  endtask

  initial begin
    logic [15:0] nextD;
    logic [3:0]  nextB;

    // Reset held: outputs dark, no frame pulse.
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 4'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset held", DARK);
    end
    rst = 1'b0;
    waitFirstFrame("reset release");

    // Empty shadow shows nothing; load 4321 mid-frame.
    runFrame("frame dark", 16'h0000, 4'hF, 5, 16'h4321, 4'h0, 0, 16'h0, 4'h0);
    runFrame("digits 4321", 16'h4321, 4'h0, 10, 16'h0042, 4'b1100, 0, 16'h0, 4'h0);

    // Leading-zero suppression; then 1111 mid-frame and 2222 on the boundary edge.
    runFrame("blank 0042", 16'h0042, 4'b1100, 10, 16'h1111, 4'h0, 31, 16'h2222, 4'h0);
    runFrame("boundary 1111", 16'h1111, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("next 2222", 16'h2222, 4'h0, 10, 16'h0000, 4'b1110, 0, 16'h0, 4'h0);

    // Sweep digit 0 through every hex value.
    for (int v = 0; v < 16; v++) begin
      if (v == 15) begin
        nextD = 16'h0A05;
        nextB = 4'h0;
      end else begin
        nextD = 16'(v + 1);
        nextB = 4'b1110;
      end
      runFrame($sformatf("hex %0h", v), 16'(v), 4'b1110, 10, nextD, nextB, 0, 16'h0, 4'h0);
    end

    // Reset in slot 2 after dead time blanks immediately.
    for (int j = 1; j <= 2 * SCAN_DIV + 4; j++) begin
      @(negedge clk);
      checkOutput($sformatf("pre-reset j%0d", j), expectAt(16'h0A05, 4'h0, j));
    end
    rst = 1'b1;
    #1;
    checkOutput("async reset", DARK);
    @(negedge clk);
    checkOutput("reset held 2", DARK);
    rst = 1'b0;
    waitFirstFrame("mid-slot reset");

    // Scan restarts at digit 0 with an empty shadow.
    runFrame("post-reset dark", 16'h0000, 4'hF, 3, 16'h8888, 4'h0, 0, 16'h0, 4'h0);
    runFrame("digits 8888", 16'h8888, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
